// File: rtl/cpu_sequencer_pkg.sv
// Shared types and constants for the multi-cycle RV32 ALU sequencer.
package cpu_sequencer_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_t;

  typedef enum logic [6:0] {
    ALU_WITH_TWO_REGISTERS = 7'b0110011,
    ALU_WITH_IMMEDIATE     = 7'b0010011
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE          = 2'd0,
    CAUSE_ILLEGAL       = 2'd1,
    CAUSE_FETCH_TIMEOUT = 2'd2
  } trap_cause_t;

  // funct3 -> ALU operation, shared by R and I formats (f3=000 refined by caller for R).
  function automatic alu_op_t funct3_to_op(input logic [2:0] f3);
    alu_op_t op;
    op = ALU_ADD;
    case (f3)
      3'b000:         op = ALU_ADD;
      3'b001:         op = ALU_SLL;
      3'b010, 3'b011: op = ALU_SLT;
      3'b100:         op = ALU_XOR;
      3'b101:         op = ALU_SRL;
      3'b110:         op = ALU_OR;
      default:        op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic is_busy(input seq_state_t s);
    return (s != IDLE) && (s != TRAP);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Instruction-memory fetch handshake between the sequencer and imem.
interface cpu_sequencer_if;
  logic                                imem_req;
  logic                                imem_ack;
  logic [cpu_sequencer_pkg::XLEN-1:0]  imem_rdata;

  modport master (output imem_req, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, output imem_ack, output imem_rdata);
endinterface

// File: rtl/cpu_sequencer_decoder.sv
// Combinational instruction decode: opcode/funct fields -> alu_op, b-mux select, legality.
module cpu_sequencer_decoder
  import cpu_sequencer_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output alu_op_t    alu_op_o,
  output logic       use_imm_o,
  output logic       legal_o
);

  always_comb begin
    alu_op_o  = ALU_ADD;
    use_imm_o = 1'b0;
    legal_o   = 1'b0;
    case (opcode_i)
      ALU_WITH_TWO_REGISTERS: begin
        legal_o  = 1'b1;
        alu_op_o = funct3_to_op(funct3_i);
        // Only the ADD/SUB slot qualifies on funct7.
        if (funct3_i == 3'b000) begin
          if (funct7_i == 7'b0100000) begin
            alu_op_o = ALU_SUB;
          end else if (funct7_i != 7'b0000000) begin
            legal_o = 1'b0;
          end
        end
      end
      ALU_WITH_IMMEDIATE: begin
        legal_o   = 1'b1;
        use_imm_o = 1'b1;
        alu_op_o  = funct3_to_op(funct3_i);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: fetch over req/ack, decode, exec, write-back, with run/step/halt control.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int unsigned IMEM_TIMEOUT = 16,
  parameter int unsigned CNT_W        = 32,
  parameter bit          RESET_RUN    = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  input  logic              halt_req,
  cpu_sequencer_if.master   imem,
  output logic [XLEN-1:0]   ir,
  output alu_op_t           alu_op,
  output logic              use_imm,
  output logic              reg_write,
  output logic              pc_en,
  output logic              busy,
  output logic              trap,
  output trap_cause_t       trap_cause,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instret_count
);

  localparam int unsigned TMO_W = $clog2(IMEM_TIMEOUT + 1);
  localparam seq_state_t  RESET_STATE = RESET_RUN ? FETCH : IDLE;

  seq_state_t        state_q, state_d;
  logic              step_q, step_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [XLEN-1:0]   ir_q, ir_d;
  trap_cause_t       cause_q, cause_d;
  logic              imem_req_q, imem_req_d;
  logic              reg_write_q, reg_write_d;
  logic              pc_en_q, pc_en_d;
  logic              busy_q, busy_d;
  logic              trap_q, trap_d;
  logic [CNT_W-1:0]  cycle_q, instret_q;
  logic              dec_legal;

  cpu_sequencer_decoder u_dec (
    .opcode_i  (ir_q[6:0]),
    .funct3_i  (ir_q[14:12]),
    .funct7_i  (ir_q[31:25]),
    .alu_op_o  (alu_op),
    .use_imm_o (use_imm),
    .legal_o   (dec_legal)
  );

  // Next-state and registered-output decode.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    tmo_d   = tmo_q;
    ir_d    = ir_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: begin
        if (!halt_req) begin
          if (step) begin
            state_d = FETCH;
            step_d  = 1'b1;
          end else if (run) begin
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        if (imem.imem_ack) begin
          ir_d    = imem.imem_rdata;
          state_d = DECODE;
        end else if (tmo_q == TMO_W'(IMEM_TIMEOUT - 1)) begin
          state_d = TRAP;
          cause_d = CAUSE_FETCH_TIMEOUT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      DECODE: begin
        if (dec_legal) begin
          state_d = EXEC;
        end else begin
          state_d = TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      EXEC: state_d = WB;
      WB: begin
        if (step_q || halt_req) begin
          state_d = IDLE;
          step_d  = 1'b0;
        end else begin
          state_d = FETCH;
        end
      end
      TRAP: ;
      default: state_d = IDLE;
    endcase

    if ((state_d == FETCH) && (state_q != FETCH)) begin
      tmo_d = '0;
    end

    // Strobes are registered a cycle early so they line up with the state they belong to.
    imem_req_d  = (state_d == FETCH);
    pc_en_d     = (state_d == WB);
    reg_write_d = (state_d == WB) && (ir_q[11:7] != 5'd0);
    busy_d      = is_busy(state_d);
    trap_d      = (state_d == TRAP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RESET_STATE;
      step_q      <= 1'b0;
      tmo_q       <= '0;
      ir_q        <= NOP_INSN;
      cause_q     <= CAUSE_NONE;
      imem_req_q  <= (RESET_STATE == FETCH);
      reg_write_q <= 1'b0;
      pc_en_q     <= 1'b0;
      busy_q      <= is_busy(RESET_STATE);
      trap_q      <= 1'b0;
      cycle_q     <= '0;
      instret_q   <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      tmo_q       <= tmo_d;
      ir_q        <= ir_d;
      cause_q     <= cause_d;
      imem_req_q  <= imem_req_d;
      reg_write_q <= reg_write_d;
      pc_en_q     <= pc_en_d;
      busy_q      <= busy_d;
      trap_q      <= trap_d;
      if (is_busy(state_q)) begin
        cycle_q <= cycle_q + CNT_W'(1);
      end
      if (state_q == WB) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  assign imem.imem_req  = imem_req_q;
  assign ir             = ir_q;
  assign reg_write      = reg_write_q;
  assign pc_en          = pc_en_q;
  assign busy           = busy_q;
  assign trap           = trap_q;
  assign trap_cause     = cause_q;
  assign cycle_count    = cycle_q;
  assign instret_count  = instret_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized bench for cpu_sequencer with a transaction-level reference of the instruction lifecycle.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        halt_req = 1'b0;
  logic [31:0] ir;
  logic [2:0]  alu_op;
  logic        use_imm, reg_write, pc_en, busy, trap;
  logic [1:0]  trap_cause;
  logic [31:0] cycle_count, instret_count;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int exp_cycles = 0;
  int exp_instret = 0;
  int last_fetch = 0;
  int this_fetch = 0;

  cpu_sequencer_if bus ();

  cpu_sequencer #(.IMEM_TIMEOUT(16), .CNT_W(32), .RESET_RUN(1'b0)) dut (
    .clk           (clk),
    .reset         (reset),
    .run           (run),
    .step          (step),
    .halt_req      (halt_req),
    .imem          (bus),
    .ir            (ir),
    .alu_op        (alu_op),
    .use_imm       (use_imm),
    .reg_write     (reg_write),
    .pc_en         (pc_en),
    .busy          (busy),
    .trap          (trap),
    .trap_cause    (trap_cause),
    .cycle_count   (cycle_count),
    .instret_count (instret_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Decode rules written from the instruction-set table.
  function automatic void ref_decode(input logic [31:0] insn, output bit legal,
                                     output logic [2:0] op, output bit imm);
    logic [2:0] f3map [8] = '{3'd0, 3'd5, 3'd7, 3'd7, 3'd4, 3'd6, 3'd3, 3'd2};
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = insn[14:12];
    f7 = insn[31:25];
    legal = 1'b0;
    op    = 3'd0;
    imm   = 1'b0;
    if (insn[6:0] == 7'h33) begin
      legal = 1'b1;
      op    = f3map[f3];
      if (f3 == 3'd0) begin
        if (f7 == 7'h20) op = 3'd1;
        else if (f7 != 7'h00) legal = 1'b0;
      end
    end else if (insn[6:0] == 7'h13) begin
      legal = 1'b1;
      imm   = 1'b1;
      op    = f3map[f3];
    end
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 1) == 1) begin
      w[6:0] = 7'h33;
      if (w[14:12] == 3'd0) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    end else begin
      w[6:0] = 7'h13;
    end
    if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_cycles  = 0;
    exp_instret = 0;
  endtask

  // Serve one fetch with the given wait states and follow the instruction to retirement or trap.
  task automatic do_insn(input logic [31:0] insn, input int waits, input bit halt_mid);
    int n;
    bit legal;
    bit imm;
    logic [2:0] op;
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fetch_req", 32'(bus.imem_req), 32'd1);
    last_fetch = this_fetch;
    this_fetch = cyc;
    if (halt_mid) halt_req = 1'b1;
    for (int w = 0; w < waits; w++) begin
      check("fetch_wait_req", 32'(bus.imem_req), 32'd1);
      @(negedge clk);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = insn;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
    ref_decode(insn, legal, op, imm);
    exp_cycles += waits + 2;
    check("dec_ir", ir, insn);
    check("dec_req", 32'(bus.imem_req), 32'd0);
    check("dec_strobes", 32'({reg_write, pc_en}), 32'd0);
    if (!legal) begin
      @(negedge clk);
      check("ill_trap", 32'(trap), 32'd1);
      check("ill_cause", 32'(trap_cause), 32'd1);
      check("ill_ir", ir, insn);
      check("ill_busy", 32'(busy), 32'd0);
      return;
    end
    check("dec_op", 32'(alu_op), 32'(op));
    check("dec_imm", 32'(use_imm), 32'(imm));
    @(negedge clk);
    check("exec_strobes", 32'({reg_write, pc_en}), 32'd0);
    check("exec_op", 32'(alu_op), 32'(op));
    @(negedge clk);
    check("wb_pc_en", 32'(pc_en), 32'd1);
    check("wb_reg_write", 32'(reg_write), 32'(insn[11:7] != 5'd0));
    check("wb_op", 32'(alu_op), 32'(op));
    check("wb_imm", 32'(use_imm), 32'(imm));
    exp_cycles += 2;
    exp_instret++;
    @(negedge clk);
    check("post_pc_en", 32'(pc_en), 32'd0);
    check("cycle_count", cycle_count, 32'(exp_cycles));
    check("instret_count", instret_count, 32'(exp_instret));
    if (halt_mid) check("halt_to_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    bit seen_pc;
    bit hm;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'd0;
    do_reset();
    check("rst_ir", ir, 32'h0000_0013);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_cause", 32'(trap_cause), 32'd0);
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_strobes", 32'({reg_write, pc_en}), 32'd0);
    check("rst_cycles", cycle_count, 32'd0);
    check("rst_instret", instret_count, 32'd0);

    // addi then sub x0 back to back, zero-wait memory
    run = 1'b1;
    do_insn(32'h0050_0093, 0, 1'b0);
    do_insn(32'h4020_8033, 0, 1'b0);
    check("throughput", 32'(this_fetch - last_fetch), 32'd4);

    // ack on the last permitted fetch cycle, then halt during a 3-wait fetch
    do_insn(32'h00A0_0113, 15, 1'b0);
    do_insn(32'h0011_0193, 3, 1'b1);
    repeat (2) begin
      @(negedge clk);
      check("halt_hold", 32'(busy), 32'd0);
    end
    halt_req = 1'b0;

    for (int i = 0; i < 40; i++) begin
      hm = ($urandom_range(0, 7) == 0);
      do_insn(rand_insn(), int'($urandom_range(0, 5)), hm);
      if (hm) begin
        @(negedge clk);
        check("halt_hold_rand", 32'(busy), 32'd0);
        halt_req = 1'b0;
      end
    end

    // single step from IDLE
    run = 1'b0;
    halt_req = 1'b0;
    do_reset();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    do_insn(32'h0050_0093, 0, 1'b0);
    check("step_busy", 32'(busy), 32'd0);
    check("step_cycles", cycle_count, 32'd4);
    check("step_instret", instret_count, 32'd1);
    repeat (3) @(negedge clk);
    check("step_stays_idle", 32'(busy), 32'd0);

    // fetch timeout
    do_reset();
    run = 1'b1;
    n = 0;
    seen_pc = 1'b0;
    for (int k = 0; k < 40 && !trap; k++) begin
      @(negedge clk);
      if (bus.imem_req) n++;
      if (pc_en) seen_pc = 1'b1;
    end
    check("tmo_cycles", 32'(n), 32'd16);
    check("tmo_trap", 32'(trap), 32'd1);
    check("tmo_cause", 32'(trap_cause), 32'd2);
    check("tmo_no_pc_en", 32'(seen_pc), 32'd0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0050_0093;
    repeat (5) @(negedge clk);
    check("tmo_sticky", 32'(trap), 32'd1);
    check("tmo_no_req", 32'(bus.imem_req), 32'd0);
    check("tmo_frozen_cycles", cycle_count, 32'd16);
    check("tmo_instret", instret_count, 32'd0);
    check("tmo_ir", ir, 32'h0000_0013);
    bus.imem_ack = 1'b0;

    // illegal opcode, then illegal R-type funct7
    do_reset();
    do_insn(32'h0000_007F, 0, 1'b0);
    repeat (3) @(negedge clk);
    check("ill_frozen_cycles", cycle_count, 32'(exp_cycles));
    check("ill_sticky", 32'(trap), 32'd1);
    do_reset();
    do_insn(32'h0200_0033, 1, 1'b0);
    check("ill_r_instret", instret_count, 32'd0);

    // reset while in EXEC
    do_reset();
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rx_fetch", 32'(bus.imem_req), 32'd1);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0050_0093;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    @(negedge clk);
    check("rx_exec_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    run = 1'b0;
    check("rx_busy", 32'(busy), 32'd0);
    check("rx_ir", ir, 32'h0000_0013);
    check("rx_cycles", cycle_count, 32'd0);
    check("rx_instret", instret_count, 32'd0);
    check("rx_strobes", 32'({reg_write, pc_en}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rx_after_strobes", 32'({reg_write, pc_en}), 32'd0);
    check("rx_after_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
    $fatal(1);
  end

endmodule
